pipelined_adder_nbit: RTL and testbench

- Parametrised, pipelined ripple-carry adder. Successor to the team's 4-bit behavioural adder.
- Splits a WIDTH-bit add into SLICE_W-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Accepts one operand pair per cycle under a valid/ready handshake with backpressure.
- Used as the arithmetic datapath element wherever a wide add must close timing at full clock rate.

---
 rtl/pipelined_adder_nbit_pkg.sv | 5 +
 rtl/pipelined_adder_nbit_slice.sv | 12 +
 rtl/pipelined_adder_nbit.sv | 101 ++++++++++
 tb/tb_pipelined_adder_nbit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_nbit_pkg.sv
// pipelined_adder_nbit_pkg: default geometry shared by the pipelined adder and its users
package pipelined_adder_nbit_pkg;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SLICE_W = 4;
endpackage

// File: rtl/pipelined_adder_nbit_slice.sv
// adder_slice: combinational SLICE_W-bit add with carry in and carry out
module adder_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: one slice per stage pipelined adder with valid/ready; PIPE_ADDER_SIGNED_OVF_EN adds signed overflow
module pipelined_adder_nbit
    import pipelined_adder_nbit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_SIGNED_OVF_EN
    output logic             overflow,
`endif
    output logic             carry_out
);
    localparam int NUM_STAGES = WIDTH / SLICE_W;
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    for (genvar k = 0; k < NUM_STAGES; k++) begin : stg
        localparam int LO = k * SLICE_W;
        logic [WIDTH-LO-1:0]   a_src, b_src;
        logic [LO+SLICE_W-1:0] s_d, s_q;
        logic [SLICE_W-1:0]    slice_sum;
        logic                  v_in, c_in, c_out, v_q, c_q;
`ifdef PIPE_ADDER_SIGNED_OVF_EN
        logic [1:0]            sgn_in, sgn_q;
`endif
        if (k == 0) begin : src
            assign a_src  = a;
            assign b_src  = b;
            assign v_in   = in_valid;
            assign c_in   = carry_in;
            assign s_d    = slice_sum;
`ifdef PIPE_ADDER_SIGNED_OVF_EN
            assign sgn_in = {a[WIDTH-1], b[WIDTH-1]};
`endif
        end else begin : src
            assign a_src  = stg[k-1].skw.a_q;
            assign b_src  = stg[k-1].skw.b_q;
            assign v_in   = stg[k-1].v_q;
            assign c_in   = stg[k-1].c_q;
            assign s_d    = {slice_sum, stg[k-1].s_q};
`ifdef PIPE_ADDER_SIGNED_OVF_EN
            assign sgn_in = stg[k-1].sgn_q;
`endif
        end
        adder_slice #(.SLICE_W(SLICE_W)) u_add (
            .a    (a_src[SLICE_W-1:0]),
            .b    (b_src[SLICE_W-1:0]),
            .cin  (c_in),
            .sum  (slice_sum),
            .cout (c_out)
        );
        // stage register: valid, carry and completed low sum slices advance together unless stalled
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
`ifdef PIPE_ADDER_SIGNED_OVF_EN
                sgn_q <= 2'b00;
`endif
            end else if (en) begin
                v_q   <= v_in;
                c_q   <= c_out;
                s_q   <= s_d;
`ifdef PIPE_ADDER_SIGNED_OVF_EN
                sgn_q <= sgn_in;
`endif
            end
        end
        if (k < NUM_STAGES - 1) begin : skw
            logic [WIDTH-LO-SLICE_W-1:0] a_q, b_q;
            // skew register: operand bits above this slice wait for their own stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_src[WIDTH-LO-1:SLICE_W];
                    b_q <= b_src[WIDTH-LO-1:SLICE_W];
                end
            end
        end
    end
    assign out_valid = stg[NUM_STAGES-1].v_q;
    assign sum       = stg[NUM_STAGES-1].s_q;
    assign carry_out = stg[NUM_STAGES-1].c_q;
`ifdef PIPE_ADDER_SIGNED_OVF_EN
    assign overflow  = (stg[NUM_STAGES-1].sgn_q[1] == stg[NUM_STAGES-1].sgn_q[0]) &&
                       (sum[WIDTH-1] != stg[NUM_STAGES-1].sgn_q[1]);
`endif
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// tb_pipelined_adder_nbit: directed self-checking bench for the pipelined adder
module tb_pipelined_adder_nbit;
    logic        clk, reset, in_valid, in_ready, out_valid, out_ready, carry_in, carry_out;
    logic [15:0] a, b, sum;
`ifdef PIPE_ADDER_SIGNED_OVF_EN
    logic        overflow;
`endif
    int checks = 0;
    int errors = 0;

    pipelined_adder_nbit #(.WIDTH(16), .SLICE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPE_ADDER_SIGNED_OVF_EN
        .overflow  (overflow),
`endif
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", carry_out); end
`ifdef PIPE_ADDER_SIGNED_OVF_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
`endif
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h0FED; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; lat = 1;
        #1;
        while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; #1; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency got %0d want 4", lat); end
        checks++; if (sum !== 16'h2221) begin errors++; $display("FAIL single_sum got %h want 2221", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL single_cout got %b want 0", carry_out); end
    endtask

    task automatic test_ripple();
        int lat;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; carry_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; lat = 1;
        #1;
        while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; #1; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency got %0d want 4", lat); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL ripple_sum got %h want 0000", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b want 1", carry_out); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc < 8) begin
                in_valid = 1'b1; a = 16'(cyc + 1); b = 16'(16 - (cyc + 1)); carry_in = 1'((cyc + 1) % 2);
            end else in_valid = 1'b0;
            #1;
            exp_v = (cyc >= 4 && cyc < 12);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cyc %0d got %b want %b", cyc, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (sum !== 16'(16 + (cyc - 3) % 2)) begin errors++; $display("FAIL b2b_sum cyc %0d got %h want %h", cyc, sum, 16'(16 + (cyc - 3) % 2)); end
                checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL b2b_cout cyc %0d got %b want 0", cyc, carry_out); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] va [6] = '{16'h00FF, 16'h0FFF, 16'hABCD, 16'h8000, 16'h1234, 16'hFFFE};
        logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h1111, 16'h8000, 16'h4321, 16'h0001};
        logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] vs [6] = '{16'h0100, 16'h1000, 16'hBCDE, 16'h0000, 16'h5556, 16'h0000};
        logic        vo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int tx = 0;
        int rx = 0;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = (tx < 6);
            if (tx < 6) begin a = va[tx]; b = vb[tx]; carry_in = vc[tx]; end
            #1;
            if (!out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", cyc, in_ready); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", cyc, out_valid); end
            end
            if (out_valid === 1'b1) begin
                checks++; if (sum !== vs[rx]) begin errors++; $display("FAIL bp_sum idx %0d got %h want %h", rx, sum, vs[rx]); end
                checks++; if (carry_out !== vo[rx]) begin errors++; $display("FAIL bp_cout idx %0d got %b want %b", rx, carry_out, vo[rx]); end
                if (out_ready) rx++;
            end
            if (in_valid && in_ready === 1'b1) tx++;
        end
        checks++; if (rx !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", rx); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_valid got %b want 0", out_valid); end
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(16'h1111 * (cyc + 1)); b = 16'h0101; carry_in = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
        checks++; if (sum !== 16'h1212) begin errors++; $display("FAIL rst_pre_sum got %h want 1212", sum); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL rst_async_sum got %h want 0000", sum); end
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cyc %0d got %b want 0", cyc, out_valid); end
        end
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; carry_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; lat = 1;
        #1;
        while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; #1; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_new_latency got %0d want 4", lat); end
        checks++; if (sum !== 16'h0003) begin errors++; $display("FAIL rst_new_sum got %h want 0003", sum); end
    endtask

`ifdef PIPE_ADDER_SIGNED_OVF_EN
    task automatic test_overflow();
        logic [15:0] va [3] = '{16'h7FFF, 16'h8000, 16'h1234};
        logic [15:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h0FED};
        logic [15:0] vs [3] = '{16'h8000, 16'h7FFF, 16'h2221};
        logic        vo [3] = '{1'b0, 1'b1, 1'b0};
        logic        vv [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; carry_in = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; lat = 1;
            #1;
            while (out_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; #1; end
            checks++; if (sum !== vs[i]) begin errors++; $display("FAIL ovf_sum %0d got %h want %h", i, sum, vs[i]); end
            checks++; if (carry_out !== vo[i]) begin errors++; $display("FAIL ovf_cout %0d got %b want %b", i, carry_out, vo[i]); end
            checks++; if (overflow !== vv[i]) begin errors++; $display("FAIL ovf_flag %0d got %b want %b", i, overflow, vv[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ripple();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
`ifdef PIPE_ADDER_SIGNED_OVF_EN
        test_overflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
